cluster_unpacker: RTL and testbench
===================================

Name: cluster_unpacker

Overview:
Rebuilds the 1536-bit VFAT pad/strip bitmap from the stream of packed cluster words that the cluster packer emits. Sits on the receive/monitor side, for example in the loopback checker or the trigger-side emulator.
- Accepts at most one cluster (address plus size) per clock over an 8-clock frame.
- ORs each cluster's strip span into an accumulator.
- Presents the completed bitmap, with a one-clock valid strobe, at each frame boundary.

Parameters:
NSBITS, 1536, bitmap width in strips
MXCLUSTERS, 8, maximum clusters accepted per frame; further clusters are dropped and flagged
FRAME_LEN, 8, clocks per frame; must be a power of 2

Ports:
clock  in  1  fabric clock, 160 MHz
global_reset_n  in  1  asynchronous, active-low reset
frame_sync  in  1  marks the current cycle as phase 0 of a frame
cluster_vld  in  1  cluster word valid this cycle
cluster_adr  in  11  first strip of the cluster, 0..1535
cluster_cnt  in  3  cluster size minus 1 (1..8 strips)
vpfs_out  out  1536  reconstructed bitmap of the last completed frame
vpfs_vld  out  1  one-clock strobe when vpfs_out updates
overflow  out  1  sticky this frame; more than MXCLUSTERS clusters were seen
bad_adr  out  1  one-clock pulse when a cluster with adr >= 1536 is dropped
resync  out  1  one-clock pulse when frame_sync arrives at phase != 0
err_cnt  out  16  saturating error count (see Optional Feature)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - vpfs_out=0, vpfs_vld=0, overflow=0, bad_adr=0, resync=0, err_cnt=0.
  - Accumulator=0, phase=0, cluster count=0, state IDLE.
- State IDLE:
  - cluster_vld is ignored.
  - frame_sync -> ACCUM, with phase=0 on this cycle. A cluster presented in the same cycle is accepted into the new frame.
- State ACCUM:
  - Phase increments every clock and wraps from FRAME_LEN-1 to 0.
- Cluster accept, when in ACCUM with cluster_vld=1, adr<NSBITS and count<MXCLUSTERS:
  - accum |= mask, where mask has bits adr..min(adr+cnt, NSBITS-1) set.
  - Spans running past strip 1535 are clipped silently; this is not an error.
- adr >= NSBITS: cluster dropped, bad_adr pulses the next clock, and it does not count toward MXCLUSTERS.
- Count already at MXCLUSTERS: cluster dropped and overflow set. overflow stays high until the frame is emitted, then clears with the next frame.
- Frame end, on the phase=FRAME_LEN-1 clock:
  - On the next edge, vpfs_out <= accum | mask_of_this_cycle's_accepted_cluster.
  - vpfs_vld=1 for one clock; accumulator and count clear.
  - Latency: the last-phase cluster appears on vpfs_out 1 clock after it is presented.
- frame_sync at phase 0 in ACCUM: no effect.
- frame_sync at phase != 0:
  - Partial frame discarded (accumulator, count and overflow cleared, no vpfs_vld).
  - resync pulses and phase restarts at 0.
  - A cluster in that cycle belongs to the new frame.
- vpfs_out holds its value between strobes. An empty frame still strobes, with an all-zero bitmap.
- Mask build is pipeline-free. The 1536-bit OR must close timing at 160 MHz. The mask decode may be split into 16 segments of 96 bits, each enabled by segment-range compare.

Optional Feature:
CLUSTER_UNPACKER_ERR_COUNT_EN
- Defined:
  - err_cnt increments by 1 per clock in which any of bad_adr, resync, or a new overflow drop occurs.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: err_cnt is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package cluster_pkg:
  - NSBITS=1536, ADR_BITS=11, CNT_BITS=3, MXSEGS=16, SEGSIZE=96.
  - Packed cluster_t {adr[10:0], cnt[2:0]}.
  - Sentinel INVALID_ADR=11'h7FE, the same idle value the packer emits.
- Sub-module cluster_strip_mask: purely combinational. Takes adr, cnt and an enable and produces the NSBITS mask, segmented per SEGSIZE. It is reused by the checker.
- The top module holds the FSM, phase counter, accumulator, output registers and error logic.

Test Plan:
- Reset, then frame_sync, then clusters (adr=0,cnt=0), (adr=100,cnt=7), (adr=1535,cnt=0) at phases 1..3 -> 1 clock after phase 7: vpfs_vld=1; vpfs_out bits 0, 100..107 and 1535 set, all others 0.
- Cluster adr=1532, cnt=7 -> bits 1532..1535 only; bad_adr=0.
- 9 valid clusters adr=0,10,..,80, cnt=0, one per phase plus a cluster on the frame_sync cycle -> first 8 set; bit 80 absent; overflow=1 until the strobe, then 0 in the next frame.
- cluster_adr=11'h7FE with vld=1 -> bad_adr pulse, bitmap unchanged, err_cnt=1 with CLUSTER_UNPACKER_ERR_COUNT_EN.
- frame_sync reasserted at phase 4 after a cluster at adr=50 -> resync pulse, no vpfs_vld; next strobe 8 clocks later without bit 50.
- global_reset_n low mid-frame with a partial accumulator -> all outputs 0 immediately; after release, clusters are ignored until frame_sync.

Source files
------------

// File: rtl/cluster_unpacker_pkg.sv
// Shared constants and types for the cluster unpacker and its strip-mask decoder.
package cluster_pkg;
  localparam int unsigned NSBITS   = 1536;
  localparam int unsigned ADR_BITS = 11;
  localparam int unsigned CNT_BITS = 3;
  localparam int unsigned MXSEGS   = 16;
  localparam int unsigned SEGSIZE  = 96;

  // Idle address the packer emits when it has no cluster to send.
  localparam logic [ADR_BITS-1:0] INVALID_ADR = 11'h7FE;

  typedef struct packed {
    logic [ADR_BITS-1:0] adr;
    logic [CNT_BITS-1:0] cnt;
  } cluster_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  function automatic logic adr_in_range(input logic [ADR_BITS-1:0] adr);
    return adr < ADR_BITS'(NSBITS);
  endfunction
endpackage

// File: rtl/cluster_unpacker_if.sv
// Cluster word input and reconstructed bitmap output bundle of the cluster unpacker.
interface cluster_unpacker_if;
  import cluster_pkg::*;

  logic                frame_sync;
  logic                cluster_vld;
  logic [ADR_BITS-1:0] cluster_adr;
  logic [CNT_BITS-1:0] cluster_cnt;
  logic [NSBITS-1:0]   vpfs_out;
  logic                vpfs_vld;
  logic                overflow;
  logic                bad_adr;
  logic                resync;
  logic [15:0]         err_cnt;

  modport master (
    output frame_sync, cluster_vld, cluster_adr, cluster_cnt,
    input  vpfs_out, vpfs_vld, overflow, bad_adr, resync, err_cnt
  );

  modport slave (
    input  frame_sync, cluster_vld, cluster_adr, cluster_cnt,
    output vpfs_out, vpfs_vld, overflow, bad_adr, resync, err_cnt
  );
endinterface

// File: rtl/cluster_strip_mask.sv
// Combinational decode of one cluster (first strip + size-1) into an NSBITS strip mask,
// split into SEGSIZE-wide segments that are only enabled when the span touches them.
module cluster_strip_mask
  import cluster_pkg::*;
(
  input  logic                en_i,
  input  logic [ADR_BITS-1:0] adr_i,
  input  logic [CNT_BITS-1:0] cnt_i,
  output logic [NSBITS-1:0]   mask_o
);
  localparam int unsigned AW = ADR_BITS + 1;

  logic [AW-1:0] first_s;
  logic [AW-1:0] last_s;
  logic [AW-1:0] span_s;

  assign first_s = {1'b0, adr_i};
  assign span_s  = {{(AW-CNT_BITS){1'b0}}, cnt_i};
  assign last_s  = first_s + span_s;

  // Bits past the last strip do not exist, so spans running off the end clip for free.
  for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
    localparam int unsigned BASE = s * SEGSIZE;
    logic seg_en_s;

    assign seg_en_s = en_i && (first_s <= AW'(BASE + SEGSIZE - 1)) && (last_s >= AW'(BASE));

    for (genvar b = 0; b < SEGSIZE; b++) begin : g_bit
      logic [AW-1:0] off_s;
      assign off_s              = AW'(BASE + b) - first_s;
      assign mask_o[BASE + b]   = seg_en_s && (off_s <= span_s);
    end
  end
endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the strip bitmap from packed cluster words, one bitmap per FRAME_LEN-clock frame.
// Optional saturating error counter enabled by CLUSTER_UNPACKER_ERR_COUNT_EN.
module cluster_unpacker
  import cluster_pkg::*;
#(
  parameter int unsigned MXCLUSTERS = 8,
  parameter int unsigned FRAME_LEN  = 8
) (
  input  logic              clock,
  input  logic              global_reset_n,
  cluster_unpacker_if.slave bus
);
  localparam int unsigned PH_BITS = $clog2(FRAME_LEN);
  localparam int unsigned CNT_W   = $clog2(MXCLUSTERS + 1);

  state_t              state_q;
  logic [PH_BITS-1:0]  phase_q;
  logic [CNT_W-1:0]    count_q;
  logic [NSBITS-1:0]   accum_q;
  logic [NSBITS-1:0]   vpfs_out_q;
  logic                vpfs_vld_q;
  logic                overflow_q;
  logic                bad_adr_q;
  logic                resync_q;

  cluster_t            clu_s;
  logic                in_frame_s, restart_s, adr_ok_s, take_s;
  logic                accept_s, drop_ovf_s, bad_s, last_s, ovf_s, room_s;
  logic [PH_BITS-1:0]  phase_s;
  logic [CNT_W-1:0]    count_s;
  logic [NSBITS-1:0]   base_s, mask_s, merged_s;

  assign clu_s = '{adr: bus.cluster_adr, cnt: bus.cluster_cnt};

  // A frame_sync always starts phase 0 this very cycle; a late one also throws away the partial frame.
  assign in_frame_s = (state_q == ST_ACCUM) || bus.frame_sync;
  assign restart_s  = bus.frame_sync && (state_q == ST_ACCUM) && (phase_q != '0);
  assign phase_s    = bus.frame_sync ? '0 : phase_q;
  assign count_s    = restart_s ? '0 : count_q;
  assign base_s     = restart_s ? '0 : accum_q;
  assign ovf_s      = restart_s ? 1'b0 : overflow_q;

  assign adr_ok_s   = adr_in_range(clu_s.adr);
  assign take_s     = in_frame_s && bus.cluster_vld;
  assign room_s     = count_s < CNT_W'(MXCLUSTERS);
  assign accept_s   = take_s && adr_ok_s && room_s;
  assign drop_ovf_s = take_s && adr_ok_s && !room_s;
  assign bad_s      = take_s && !adr_ok_s;
  assign last_s     = in_frame_s && (phase_s == PH_BITS'(FRAME_LEN - 1));
  assign merged_s   = base_s | mask_s;

  cluster_strip_mask u_mask (
    .en_i   (accept_s),
    .adr_i  (clu_s.adr),
    .cnt_i  (clu_s.cnt),
    .mask_o (mask_s)
  );

  // Frame FSM, phase counter, accumulator and all registered outputs
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      count_q    <= '0;
      accum_q    <= '0;
      vpfs_out_q <= '0;
      vpfs_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      bad_adr_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      bad_adr_q <= bad_s;
      resync_q  <= restart_s;
      if (bus.frame_sync) begin
        state_q <= ST_ACCUM;
      end
      phase_q <= in_frame_s ? phase_s + PH_BITS'(1) : '0;
      if (last_s) begin
        vpfs_out_q <= merged_s;
        vpfs_vld_q <= 1'b1;
        accum_q    <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        vpfs_vld_q <= 1'b0;
        accum_q    <= merged_s;
        count_q    <= accept_s ? count_s + CNT_W'(1) : count_s;
        overflow_q <= ovf_s | drop_ovf_s;
      end
    end
  end

  assign bus.vpfs_out = vpfs_out_q;
  assign bus.vpfs_vld = vpfs_vld_q;
  assign bus.overflow = overflow_q;
  assign bus.bad_adr  = bad_adr_q;
  assign bus.resync   = resync_q;

`ifdef CLUSTER_UNPACKER_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  // One count per clock with any error event, saturating at all-ones
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      err_cnt_q <= 16'h0000;
    end else if ((bad_s || restart_s || drop_ovf_s) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_cluster_unpacker.sv
// Self-checking bench: table of frames through a scoreboard, plus overflow, resync and reset sequences.
module tb_cluster_unpacker;
  import cluster_pkg::*;

`ifdef CLUSTER_UNPACKER_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic global_reset_n = 1'b1;
  always #5 clock = ~clock;

  cluster_unpacker_if if1 ();
  cluster_unpacker_if if2 ();

  cluster_unpacker u_dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .bus            (if1.slave)
  );

  // Longer frame so that nine clusters fit into one frame and the limit can be exceeded.
  cluster_unpacker #(.MXCLUSTERS(8), .FRAME_LEN(16)) u_dut16 (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .bus            (if2.slave)
  );

  typedef struct {
    logic [7:0]       vld;
    logic [7:0][10:0] adr;
    logic [7:0][2:0]  cnt;
    int               exp_ones;
    int               exp_bad;
  } frame_vec_t;

  typedef struct {
    logic [NSBITS-1:0] bits;
    int                ones;
    int                cyc;
  } exp_t;

  frame_vec_t vecs [6];
  exp_t       sb_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bad_pulses = 0;
  int resync_pulses = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_int(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bits(input string name, input logic [NSBITS-1:0] act, input logic [NSBITS-1:0] exp);
    int first;
    total++;
    if (act !== exp) begin
      first = -1;
      for (int i = NSBITS - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      bad++;
      $display("FAIL %s: got ones=%0d expected ones=%0d first differing strip=%0d",
               name, $countones(act), $countones(exp), first);
    end
  endtask

  // Reference: first 8 in-range clusters of the frame, spans clipped at the top strip.
  function automatic logic [NSBITS-1:0] model_bits(input frame_vec_t v);
    logic [NSBITS-1:0] m;
    int n;
    m = '0;
    n = 0;
    for (int p = 0; p < 8; p++) begin
      if (v.vld[p] && v.adr[p] < 11'd1536 && n < 8) begin
        for (int k = 0; k <= int'(v.cnt[p]); k++)
          if (int'(v.adr[p]) + k < 1536) m[int'(v.adr[p]) + k] = 1'b1;
        n++;
      end
    end
    return m;
  endfunction

  // Monitor: pulse counting and scoreboard pop on every bitmap strobe
  always @(negedge clock) begin
    if (if1.bad_adr === 1'b1) bad_pulses++;
    if (if1.resync === 1'b1) resync_pulses++;
    if (if1.vpfs_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got vpfs_vld=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_bits("frame_bits", if1.vpfs_out, e.bits);
        check_int("frame_ones", $countones(if1.vpfs_out), e.ones);
        check_int("strobe_cycle", cyc, e.cyc);
        check_int("overflow_at_strobe", if1.overflow, 0);
      end
    end
  end

  task automatic drive1(input logic sync, input logic vld, input logic [10:0] adr, input logic [2:0] cnt);
    if1.frame_sync  = sync;
    if1.cluster_vld = vld;
    if1.cluster_adr = adr;
    if1.cluster_cnt = cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic drive2(input logic sync, input logic vld, input logic [10:0] adr);
    if2.frame_sync  = sync;
    if2.cluster_vld = vld;
    if2.cluster_adr = adr;
    if2.cluster_cnt = 3'd0;
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input frame_vec_t v, input logic sync_first);
    exp_t e;
    for (int p = 0; p < 8; p++) begin
      if (p == 7) begin
        e.bits = model_bits(v);
        e.ones = v.exp_ones;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
      end
      drive1(sync_first && (p == 0), v.vld[p], v.adr[p], v.cnt[p]);
    end
  endtask

  task automatic set_cl(input int f, input int p, input int adr, input int cnt);
    vecs[f].vld[p] = 1'b1;
    vecs[f].adr[p] = 11'(adr);
    vecs[f].cnt[p] = 3'(cnt);
  endtask

  function automatic frame_vec_t one_cluster(input int p, input int adr, input int ones);
    frame_vec_t v;
    v = '{vld: '0, adr: '0, cnt: '0, exp_ones: ones, exp_bad: 0};
    v.vld[p] = 1'b1;
    v.adr[p] = 11'(adr);
    return v;
  endfunction

  initial begin
    logic [NSBITS-1:0] exp16;
    int exp_bad_total;

    for (int f = 0; f < 6; f++) vecs[f] = '{vld: '0, adr: '0, cnt: '0, exp_ones: 0, exp_bad: 0};
    set_cl(0, 1, 0, 0); set_cl(0, 2, 100, 7); set_cl(0, 3, 1535, 0); vecs[0].exp_ones = 10;
    set_cl(1, 0, 1532, 7); vecs[1].exp_ones = 4;
    set_cl(2, 2, int'(INVALID_ADR), 0); set_cl(2, 5, 20, 1); vecs[2].exp_ones = 2; vecs[2].exp_bad = 1;
    for (int p = 0; p < 8; p++) set_cl(4, p, p * 100 + 5, p);
    vecs[4].exp_ones = 36;
    set_cl(5, 0, 10, 7); set_cl(5, 1, 12, 3); set_cl(5, 7, 17, 7); vecs[5].exp_ones = 15;

    if1.frame_sync = 1'b0; if1.cluster_vld = 1'b0; if1.cluster_adr = '0; if1.cluster_cnt = '0;
    if2.frame_sync = 1'b0; if2.cluster_vld = 1'b0; if2.cluster_adr = '0; if2.cluster_cnt = '0;
    #2 global_reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_bits("reset_vpfs_out", if1.vpfs_out, '0);
    check_int("reset_vpfs_vld", if1.vpfs_vld, 0);
    check_int("reset_overflow", if1.overflow, 0);
    check_int("reset_bad_adr", if1.bad_adr, 0);
    check_int("reset_resync", if1.resync, 0);
    check_int("reset_err_cnt", if1.err_cnt, 0);
    global_reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Nine clusters in one 16-clock frame: the ninth is dropped and flags overflow.
    drive2(1'b1, 1'b1, 11'd0);
    for (int i = 1; i <= 8; i++) drive2(1'b0, 1'b1, 11'(i * 10));
    check_int("ovf_set", if2.overflow, 1);
    repeat (6) drive2(1'b0, 1'b0, 11'd0);
    check_int("ovf_hold", if2.overflow, 1);
    drive2(1'b0, 1'b0, 11'd0);
    check_int("ovf_strobe", if2.vpfs_vld, 1);
    exp16 = '0;
    for (int i = 0; i < 8; i++) exp16[i * 10] = 1'b1;
    check_bits("ovf_bits", if2.vpfs_out, exp16);
    check_int("ovf_adr80_dropped", if2.vpfs_out[80], 0);
    check_int("ovf_err_cnt", if2.err_cnt, ERR_EN ? 1 : 0);
    repeat (2) drive2(1'b0, 1'b0, 11'd0);
    check_int("ovf_cleared_next_frame", if2.overflow, 0);

    // Clusters before the first frame_sync must be ignored.
    repeat (3) drive1(1'b0, 1'b1, 11'd5, 3'd0);

    exp_bad_total = 0;
    for (int f = 0; f < 6; f++) begin
      run_frame(vecs[f], f == 0);
      exp_bad_total += vecs[f].exp_bad;
    end
    drive1(1'b0, 1'b0, 11'd0, 3'd0);
    check_int("bad_adr_pulses", bad_pulses, exp_bad_total);
    check_int("err_cnt_after_bad", if1.err_cnt, ERR_EN ? 1 : 0);

    // Late frame_sync at phase 4 discards the cluster at strip 50.
    drive1(1'b0, 1'b1, 11'd50, 3'd0);
    drive1(1'b0, 1'b0, 11'd0, 3'd0);
    drive1(1'b0, 1'b0, 11'd0, 3'd0);
    run_frame(one_cluster(2, 60, 1), 1'b1);
    drive1(1'b0, 1'b0, 11'd0, 3'd0);
    check_int("resync_pulses", resync_pulses, 1);
    check_int("err_cnt_after_resync", if1.err_cnt, ERR_EN ? 2 : 0);

    // Reset in the middle of a partly filled frame.
    drive1(1'b0, 1'b1, 11'd200, 3'd3);
    drive1(1'b0, 1'b0, 11'd0, 3'd0);
    global_reset_n = 1'b0;
    #1;
    check_bits("midreset_vpfs_out", if1.vpfs_out, '0);
    check_int("midreset_err_cnt", if1.err_cnt, 0);
    check_int("midreset_vpfs_vld", if1.vpfs_vld, 0);
    repeat (2) @(posedge clock);
    #1;
    global_reset_n = 1'b1;
    repeat (10) drive1(1'b0, 1'b1, 11'd300, 3'd0);
    run_frame(one_cluster(0, 400, 1), 1'b1);
    repeat (2) drive1(1'b0, 1'b0, 11'd0, 3'd0);
    check_int("all_strobes_seen", sb_q.size(), 0);
    check_int("final_err_cnt", if1.err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
